clock_text_gen: RTL
===================

CLOCK_TEXT_GEN -- requirements
Module: clock_text_gen

Interface
REQ-001 SHALL have parameter X0, default 256, meaning the left pixel column of the text box.
REQ-002 SHALL have parameter Y0, default 224, meaning the top pixel row of the text box.
REQ-003 SHALL have parameter FG, default 12'hFFF, meaning the RGB444 colour for lit glyph pixels.
REQ-004 SHALL have parameter BG, default 12'h000, meaning the RGB444 colour for all other pixels.
REQ-005 SHALL have parameter BLINK_FRAMES, default 30, meaning the number of frames per colon on/off phase (range 1-255).
REQ-006 SHALL have port clk, input, 1 bit: the system clock, rising-edge active.
REQ-007 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have ports video_on, input, 1 bit, and p_tick, input, 1 bit: the sync generator's active-area flag and pixel enable.
REQ-009 SHALL have ports x and y, input, 10 bits each: the current pixel column and row.
REQ-010 SHALL have ports hr_10, hr_1, min_10, min_1, sec_10 and sec_1, input, 4 bits each: BCD time digits.
REQ-011 SHALL have port blink_en, input, 1 bit: 1 enables colon blinking.
REQ-012 SHALL have port rom_addr, output, 11 bits: address to the 8x16 glyph ROM, laid out as {ASCII[6:0], row[3:0]}.
REQ-013 SHALL have port rom_data, input, 8 bits: the glyph row, valid 1 clk after rom_addr; bit 7 is the leftmost pixel.
REQ-014 SHALL have ports rgb, output, 12 bits, and text_on, output, 1 bit: registered pixel colour and in-box flag.

Function
REQ-015 SHALL define the text box as X0 <= x < X0+128 and Y0 <= y < Y0+32; this is the string "HH:MM:SS" rendered at 2x scale, 16x32 px per character.
REQ-016 SHALL, with dx = x-X0 and dy = y-Y0, derive char_idx = dx[6:4], glyph_col = dx[3:1] and glyph_row = dy[4:1].
REQ-017 SHALL map char_idx 0-7 to sh_hr_10, sh_hr_1, ':', sh_min_10, sh_min_1, ':', sh_sec_10, sh_sec_1.
REQ-018 SHALL convert each digit to ASCII 0x30+d; any digit above 9 SHALL instead map to 0x2E ('.').
REQ-019 SHALL map ':' to ASCII 0x3A.
REQ-020 SHALL drive rom_addr combinationally from the current x, y and shadow digits.
REQ-021 SHALL drive rom_addr to 11'h300 when the pixel is outside the box.
REQ-022 SHALL register, every clk, stage-1 state: in_box, glyph_col, colon_sel and video_on.
REQ-023 SHALL register rgb and text_on from stage-1 state and rom_data; x/y-to-rgb latency SHALL be exactly 2 clk.
REQ-024 SHALL set lit = s1_video_on & s1_in_box & rom_data[7-s1_glyph_col] & ~(s1_colon_sel & ~colon_vis).
REQ-025 SHALL set rgb = FG when lit; otherwise rgb = BG when s1_video_on, else 12'h000.
REQ-026 SHALL set text_on = s1_video_on & s1_in_box.
REQ-027 SHALL define frame_start = p_tick & (x==0) & (y==0).
REQ-028 SHALL copy all six BCD inputs into the shadow digit registers on frame_start only, so no frame mixes old and new time.
REQ-029 SHALL count frame_start pulses in frame_cnt, 0..BLINK_FRAMES-1.
REQ-030 SHALL, on frame_start with frame_cnt = BLINK_FRAMES-1, wrap frame_cnt to 0 and toggle colon_vis.
REQ-031 SHALL force colon_vis = 1 and frame_cnt = 0 while blink_en = 0.
REQ-032 SHALL, when blink_en and frame_start coincide, let blink_en = 0 take priority.
REQ-033 SHALL mask hidden-colon pixels regardless of rom_data, because the ROM has no blank glyph.

Reset
REQ-034 SHALL, on a clk edge with reset_n = 0, force rgb = 12'h000, text_on = 0, all stage-1 registers = 0, shadow digits = 0, frame_cnt = 0 and colon_vis = 1.
REQ-035 SHALL make reset override frame_start and blink updates in the same cycle.
REQ-036 SHALL, after reset is asserted mid-frame, show "00:00:00" once reset_n returns high, until the next frame_start.

Verification
REQ-037 SHALL cover: reset, then frame_start with 12:34:56, then x=256, y=228 -> rom_addr=11'h312; 2 clk later rgb equals FG/BG per rom bit 7.
REQ-038 SHALL cover: sec_1=4'hB latched -> char 7 rom_addr row base 11'h2E0.
REQ-039 SHALL cover: BCD inputs changed mid-frame -> rom_addr unchanged until after the next frame_start.
REQ-040 SHALL cover: blink_en=1, BLINK_FRAMES=2 -> colon pixels at x=288 read BG for frames 2-3 and FG-capable for frames 0-1 and 4-5; blink_en=0 -> colon always visible.
REQ-041 SHALL cover: video_on=0 inside the box -> rgb=12'h000 and text_on=0; x=384 -> text_on=0 and rom_addr=11'h300.
REQ-042 SHALL cover: reset_n low for 1 clk mid-frame -> rgb=0 the next clk and shadow digits display "00:00:00".

Source files
------------

// File: rtl/clock_text_gen_if.sv
// Glyph ROM bus: the text generator drives the address, the ROM returns one
// 8-pixel row a clock later.
interface clock_text_gen_if;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;

    modport master (output rom_addr, input  rom_data);
    modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/clock_text_gen.sv
// Renders "HH:MM:SS" at 2x scale from an 8x16 glyph ROM, with frame-latched
// digits and an optional blinking colon. Pixel-to-rgb latency is 2 clk.
module clock_text_gen #(
    parameter int          X0           = 256,
    parameter int          Y0           = 224,
    parameter logic [11:0] FG           = 12'hFFF,
    parameter logic [11:0] BG           = 12'h000,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     video_on,
    input  logic                     p_tick,
    input  logic [9:0]               x,
    input  logic [9:0]               y,
    input  logic [3:0]               hr_10,
    input  logic [3:0]               hr_1,
    input  logic [3:0]               min_10,
    input  logic [3:0]               min_1,
    input  logic [3:0]               sec_10,
    input  logic [3:0]               sec_1,
    input  logic                     blink_en,
    clock_text_gen_if.master         rom,
    output logic [11:0]              rgb,
    output logic                     text_on
);

    localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);

    function automatic logic [6:0] bcd_ascii(input logic [3:0] d);
        return (d > 4'd9) ? 7'h2E : (7'h30 + {3'b000, d});
    endfunction

    logic [3:0] r_sh_hr_10, r_sh_hr_1, r_sh_min_10, r_sh_min_1, r_sh_sec_10, r_sh_sec_1;
    logic [7:0] r_frame_cnt;
    logic       r_colon_vis;

    logic       r_s1_in_box;
    logic [2:0] r_s1_glyph_col;
    logic       r_s1_colon_sel;
    logic       r_s1_video_on;

    logic       w_frame_start;
    logic       w_in_box;
    logic [2:0] w_char_idx;
    logic [2:0] w_glyph_col;
    logic [3:0] w_glyph_row;
    logic       w_colon_sel;
    logic [6:0] w_ascii;
    logic       w_lit;

    assign w_frame_start = p_tick && (x == 10'd0) && (y == 10'd0);

    // 11-bit compares so the box edges cannot wrap near the right/bottom border
    assign w_in_box = ({1'b0, x} >= 11'(X0)) && ({1'b0, x} < 11'(X0 + 128)) &&
                      ({1'b0, y} >= 11'(Y0)) && ({1'b0, y} < 11'(Y0 + 32));

    assign w_char_idx  = 3'((x - 10'(X0)) >> 4);
    assign w_glyph_col = 3'((x - 10'(X0)) >> 1);
    assign w_glyph_row = 4'((y - 10'(Y0)) >> 1);
    assign w_colon_sel = (w_char_idx == 3'd2) || (w_char_idx == 3'd5);

    always_comb begin
        w_ascii = 7'h3A;
        case (w_char_idx)
            3'd0:    w_ascii = bcd_ascii(r_sh_hr_10);
            3'd1:    w_ascii = bcd_ascii(r_sh_hr_1);
            3'd3:    w_ascii = bcd_ascii(r_sh_min_10);
            3'd4:    w_ascii = bcd_ascii(r_sh_min_1);
            3'd6:    w_ascii = bcd_ascii(r_sh_sec_10);
            3'd7:    w_ascii = bcd_ascii(r_sh_sec_1);
            default: w_ascii = 7'h3A;
        endcase
    end

    assign rom.rom_addr = w_in_box ? {w_ascii, w_glyph_row} : 11'h300;

    // Digits only change at frame start so a frame never mixes two times
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sh_hr_10  <= 4'd0;
            r_sh_hr_1   <= 4'd0;
            r_sh_min_10 <= 4'd0;
            r_sh_min_1  <= 4'd0;
            r_sh_sec_10 <= 4'd0;
            r_sh_sec_1  <= 4'd0;
        end else if (w_frame_start) begin
            r_sh_hr_10  <= hr_10;
            r_sh_hr_1   <= hr_1;
            r_sh_min_10 <= min_10;
            r_sh_min_1  <= min_1;
            r_sh_sec_10 <= sec_10;
            r_sh_sec_1  <= sec_1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_frame_cnt <= 8'd0;
            r_colon_vis <= 1'b1;
        end else if (!blink_en) begin
            r_frame_cnt <= 8'd0;
            r_colon_vis <= 1'b1;
        end else if (w_frame_start) begin
            if (r_frame_cnt == FRAME_LAST) begin
                r_frame_cnt <= 8'd0;
                r_colon_vis <= ~r_colon_vis;
            end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // The ROM has no blank glyph, so a hidden colon is masked here
    assign w_lit = r_s1_video_on && r_s1_in_box &&
                   rom.rom_data[3'd7 - r_s1_glyph_col] &&
                   !(r_s1_colon_sel && !r_colon_vis);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_in_box    <= 1'b0;
            r_s1_glyph_col <= 3'd0;
            r_s1_colon_sel <= 1'b0;
            r_s1_video_on  <= 1'b0;
            rgb            <= 12'h000;
            text_on        <= 1'b0;
        end else begin
            r_s1_in_box    <= w_in_box;
            r_s1_glyph_col <= w_glyph_col;
            r_s1_colon_sel <= w_colon_sel;
            r_s1_video_on  <= video_on;
            rgb            <= w_lit ? FG : (r_s1_video_on ? BG : 12'h000);
            text_on        <= r_s1_video_on && r_s1_in_box;
        end
    end

endmodule
